// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 message front end.
// Holds the MD5 initial chaining values, the block width, the pad byte,
// the feeder state encoding and the padding modes understood by the
// pad builder.
package md5_pkg;

  localparam int BLK_W = 512;

  localparam logic [31:0] MD5_IV_A = 32'h67452301;
  localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
  localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
  localparam logic [31:0] MD5_IV_D = 32'h10325476;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  // FILL collects bytes, EMIT presents a block, EXTRA presents the
  // trailing length-only block when padding did not fit.
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_EXTRA = 2'd2
  } state_t;

  // PAD_DATA       : data bytes only (full block or c=64 final block)
  // PAD_SHORT      : data, 0x80 at c, zeros, length in bytes 56..63
  // PAD_LONG       : data, 0x80 at c, zeros to byte 63, no length
  // PAD_EXTRA      : zeros plus length
  // PAD_EXTRA_MARK : 0x80 at byte 0, zeros, length
  typedef enum logic [2:0] {
    PAD_DATA       = 3'd0,
    PAD_SHORT      = 3'd1,
    PAD_LONG       = 3'd2,
    PAD_EXTRA      = 3'd3,
    PAD_EXTRA_MARK = 3'd4
  } pad_mode_t;

endpackage

// File: rtl/md5_pad_builder.sv
// Combinational MD5 block builder.
// Ports:
//   data    - raw block buffer, byte k at [8k+7:8k]; bytes at or above
//             fill may hold stale content and are masked off here
//   fill    - number of valid message bytes in data (0..64)
//   bit_len - 64-bit message length in bits
//   mode    - padding mode (see md5_pkg::pad_mode_t)
//   block   - finished 512-bit block
import md5_pkg::*;

module md5_pad_builder (
  input  logic [BLK_W-1:0] data,
  input  logic [6:0]       fill,
  input  logic [63:0]      bit_len,
  input  pad_mode_t        mode,
  output logic [BLK_W-1:0] block
);

  logic keep_data;

  assign keep_data = (mode == PAD_DATA) || (mode == PAD_SHORT) || (mode == PAD_LONG);

  // Stale bytes beyond the fill point are zeroed so the buffer never has
  // to be cleared between blocks; padding then overlays the masked data.
  always_comb begin
    block = '0;
    if (keep_data) begin
      for (int k = 0; k < 64; k++) begin
        if (7'(k) < fill) block[8*k +: 8] = data[8*k +: 8];
      end
    end
    case (mode)
      PAD_SHORT: begin
        block[{fill[5:0], 3'b000} +: 8] = PAD_BYTE;
        block[511:448] = bit_len;
      end
      PAD_LONG: begin
        block[{fill[5:0], 3'b000} +: 8] = PAD_BYTE;
      end
      PAD_EXTRA: begin
        block[511:448] = bit_len;
      end
      PAD_EXTRA_MARK: begin
        block[7:0] = PAD_BYTE;
        block[511:448] = bit_len;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md5_pad_feeder.sv
// MD5 message front end: packs a byte stream into 512-bit little-endian
// blocks and appends MD5 padding (0x80, zero fill, 64-bit bit length).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_data/in_valid/in_ready/in_last/in_empty
//                         - byte stream; in_empty with in_last marks a
//                           zero-length message
//   blk_data/blk_valid/blk_ready
//                         - block stream to the compression core
//   blk_first, blk_last   - first block of message / digest final after it
//   busy                  - message in progress or block pending
import md5_pkg::*;

module md5_pad_feeder #(
  parameter int LEN_W = 61
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             in_ready,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_valid,
  output logic             blk_first,
  output logic             blk_last,
  input  logic             blk_ready,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [BLK_W-1:0] data_q, data_nxt;
  logic [6:0]       cnt_q, cnt_nxt;
  logic [LEN_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [LEN_W+2:0] bit_cnt;
  logic [63:0]      bit_len;
  logic             first_pend, extra_pend, extra_mark;
  logic             accept, has_byte, handshake;
  logic             load_blk, set_last, set_extra, set_mark;
  pad_mode_t        mode;
  logic [BLK_W-1:0] pad_block;

  assign in_ready  = (state == ST_FILL) && !reset;
  assign blk_valid = (state != ST_FILL);
  assign accept    = in_valid && in_ready;
  assign has_byte  = accept && !(in_last && in_empty);
  assign handshake = blk_valid && blk_ready;
  assign busy      = (state != ST_FILL) || (cnt_q != 7'd0) || (byte_cnt != '0);

  // Buffer and counters as they will be once the current beat lands; the
  // completing beat's byte must already be part of the block being built.
  always_comb begin
    data_nxt = data_q;
    if (has_byte) data_nxt[{cnt_q[5:0], 3'b000} +: 8] = in_data;
    cnt_nxt      = cnt_q + {6'd0, has_byte};
    byte_cnt_nxt = byte_cnt + {{(LEN_W-1){1'b0}}, has_byte};
    bit_cnt      = {byte_cnt_nxt, 3'b000};
    bit_len      = 64'(bit_cnt);
  end

  md5_pad_builder u_builder (
    .data    (data_nxt),
    .fill    (cnt_nxt),
    .bit_len (bit_len),
    .mode    (mode),
    .block   (pad_block)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_FILL;
    else       state <= state_nxt;
  end

  // Next-state and block-load decisions. The bucket a final beat falls in
  // decides whether length fits in this block or an EXTRA block follows.
  always_comb begin
    state_nxt = state;
    mode      = PAD_DATA;
    load_blk  = 1'b0;
    set_last  = 1'b0;
    set_extra = 1'b0;
    set_mark  = 1'b0;
    case (state)
      ST_FILL: begin
        if (accept && in_last) begin
          load_blk  = 1'b1;
          state_nxt = ST_EMIT;
          if (cnt_nxt <= 7'd55) begin
            mode     = PAD_SHORT;
            set_last = 1'b1;
          end else if (cnt_nxt <= 7'd63) begin
            mode      = PAD_LONG;
            set_extra = 1'b1;
          end else begin
            mode      = PAD_DATA;
            set_extra = 1'b1;
            set_mark  = 1'b1;
          end
        end else if (accept && cnt_nxt == 7'd64) begin
          load_blk  = 1'b1;
          state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (blk_ready) begin
          if (extra_pend) begin
            mode      = extra_mark ? PAD_EXTRA_MARK : PAD_EXTRA;
            load_blk  = 1'b1;
            state_nxt = ST_EXTRA;
          end else begin
            state_nxt = ST_FILL;
          end
        end
      end
      ST_EXTRA: begin
        if (blk_ready) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // Datapath: byte collection, block register and message bookkeeping.
  // A final handshake clears the counters and arms blk_first for the
  // next message; any other handshake disarms it.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      cnt_q      <= 7'd0;
      byte_cnt   <= '0;
      first_pend <= 1'b1;
      extra_pend <= 1'b0;
      extra_mark <= 1'b0;
      blk_data   <= '0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
    end else begin
      if (state == ST_FILL) begin
        data_q   <= data_nxt;
        cnt_q    <= cnt_nxt;
        byte_cnt <= byte_cnt_nxt;
      end
      if (load_blk) begin
        blk_data <= pad_block;
        if (state == ST_FILL) begin
          blk_first  <= first_pend;
          blk_last   <= set_last;
          extra_pend <= set_extra;
          extra_mark <= set_mark;
        end else begin
          blk_first  <= 1'b0;
          blk_last   <= 1'b1;
          extra_pend <= 1'b0;
        end
      end
      if (handshake) begin
        cnt_q      <= 7'd0;
        first_pend <= blk_last;
        if (blk_last) byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_md5_pad_feeder.sv
// Directed self-checking bench for md5_pad_feeder.
module tb_md5_pad_feeder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_empty = 1'b0;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ready = 1'b0;
  logic         busy;

  int check_count = 0;
  int pass_count = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] got_d, exp_d, abc_exp;
  logic         got_f, got_l;

  md5_pad_feeder #(.LEN_W(61)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_ready (blk_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One input beat; waits (bounded) for in_ready, returns #1 after the edge.
  task automatic sendBeat(input logic [7:0] d, input logic l, input logic e);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_empty = e;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) checkOutput("in_ready_wait", 512'(in_ready), 512'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  // Sends msg_q; with_last marks the final byte, an empty queue sends an
  // empty last beat.
  task automatic applyStimulus(input bit with_last);
    if (msg_q.size() == 0) begin
      sendBeat(8'hFF, 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < msg_q.size(); i++)
        sendBeat(msg_q[i], with_last && (i == msg_q.size() - 1), 1'b0);
    end
  endtask

  // Waits (bounded) for a block, captures it, handshakes, returns at the
  // negedge after the handshake edge.
  task automatic getBlock(output logic [511:0] d, output logic f, output logic l);
    int t;
    t = 0;
    while (!blk_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) checkOutput("blk_valid_wait", 512'(blk_valid), 512'(1));
    d = blk_data;
    f = blk_first;
    l = blk_last;
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic loadAbc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  initial begin
    abc_exp = '0;
    abc_exp[31:0]    = 32'h80636261;
    abc_exp[479:448] = 32'h00000018;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 512'(in_ready), 512'(0));
    checkOutput("rst_blk_valid", 512'(blk_valid), 512'(0));
    checkOutput("rst_blk_data", blk_data, 512'(0));
    checkOutput("rst_flags", 512'({blk_first, blk_last, busy}), 512'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("in_ready_after_rst", 512'(in_ready), 512'(1));

    // "abc": single block, latency one cycle
    loadAbc();
    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("abc_latency_valid", 512'(blk_valid), 512'(1));
    checkOutput("abc_in_ready_low", 512'(in_ready), 512'(0));
    getBlock(got_d, got_f, got_l);
    checkOutput("abc_data", got_d, abc_exp);
    checkOutput("abc_first_last", 512'({got_f, got_l}), 512'(2'b11));
    checkOutput("abc_idle", 512'({blk_valid, busy, in_ready}), 512'(3'b001));

    // Empty message
    msg_q.delete();
    applyStimulus(1'b1);
    getBlock(got_d, got_f, got_l);
    exp_d = '0;
    exp_d[7:0] = 8'h80;
    checkOutput("empty_data", got_d, exp_d);
    checkOutput("empty_first_last", 512'({got_f, got_l}), 512'(2'b11));

    // 55 zero bytes: padding and length fit
    msg_q.delete();
    for (int i = 0; i < 55; i++) msg_q.push_back(8'h00);
    applyStimulus(1'b1);
    getBlock(got_d, got_f, got_l);
    exp_d = '0;
    exp_d[447:440] = 8'h80;
    exp_d[463:448] = 16'h01B8;
    checkOutput("b55_data", got_d, exp_d);
    checkOutput("b55_first_last", 512'({got_f, got_l}), 512'(2'b11));

    // 56 bytes of 0x5A: length spills into an EXTRA block
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'h5A);
    applyStimulus(1'b1);
    getBlock(got_d, got_f, got_l);
    exp_d = '0;
    for (int i = 0; i < 56; i++) exp_d[8*i +: 8] = 8'h5A;
    exp_d[455:448] = 8'h80;
    checkOutput("b56_blk1_data", got_d, exp_d);
    checkOutput("b56_blk1_flags", 512'({got_f, got_l}), 512'(2'b10));
    checkOutput("b56_extra_valid_next", 512'(blk_valid), 512'(1));
    checkOutput("b56_extra_in_ready", 512'(in_ready), 512'(0));
    getBlock(got_d, got_f, got_l);
    exp_d = '0;
    exp_d[463:448] = 16'h01C0;
    checkOutput("b56_blk2_data", got_d, exp_d);
    checkOutput("b56_blk2_flags", 512'({got_f, got_l}), 512'(2'b01));

    // 64 bytes 0..63: full data block then 0x80 + length block
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'(i));
    applyStimulus(1'b1);
    getBlock(got_d, got_f, got_l);
    exp_d = '0;
    for (int i = 0; i < 64; i++) exp_d[8*i +: 8] = 8'(i);
    checkOutput("b64_blk1_data", got_d, exp_d);
    checkOutput("b64_blk1_flags", 512'({got_f, got_l}), 512'(2'b10));
    getBlock(got_d, got_f, got_l);
    exp_d = '0;
    exp_d[7:0] = 8'h80;
    exp_d[463:448] = 16'h0200;
    checkOutput("b64_blk2_data", got_d, exp_d);
    checkOutput("b64_blk2_flags", 512'({got_f, got_l}), 512'(2'b01));

    // Back-to-back "abc" after the 64-byte message: first again, no stale bytes
    loadAbc();
    applyStimulus(1'b1);
    getBlock(got_d, got_f, got_l);
    checkOutput("b2b_data", got_d, abc_exp);
    checkOutput("b2b_first_last", 512'({got_f, got_l}), 512'(2'b11));

    // Backpressure: hold blk_ready low for 5 cycles while offering bytes
    loadAbc();
    applyStimulus(1'b1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_data_stable", blk_data, abc_exp);
      checkOutput("bp_ctrl", 512'({blk_valid, blk_first, blk_last, in_ready}), 512'(4'b1110));
    end
    in_valid = 1'b0;
    getBlock(got_d, got_f, got_l);
    checkOutput("bp_data", got_d, abc_exp);
    loadAbc();
    applyStimulus(1'b1);
    getBlock(got_d, got_f, got_l);
    checkOutput("bp_followup_data", got_d, abc_exp);

    // Reset mid-message discards the partial block
    msg_q.delete();
    for (int i = 0; i < 10; i++) msg_q.push_back(8'hC3);
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("mid_busy", 512'(busy), 512'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_in_ready", 512'(in_ready), 512'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_state", 512'({blk_valid, busy, in_ready}), 512'(3'b001));
    loadAbc();
    applyStimulus(1'b1);
    getBlock(got_d, got_f, got_l);
    checkOutput("post_rst_data", got_d, abc_exp);
    checkOutput("post_rst_first_last", 512'({got_f, got_l}), 512'(2'b11));

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

endmodule
